// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, colour type and fetch FSM states
package vga_pkg;
  typedef logic [15:0] rgb565_t;
  typedef enum logic [1:0] {IDLE, REQ, CAPT} fetch_t;
  localparam logic [9:0] DEF_H_ACTIVE = 10'd640;
  localparam logic [9:0] DEF_H_FP = 10'd16;
  localparam logic [9:0] DEF_H_SYNC = 10'd96;
  localparam logic [9:0] DEF_H_BP = 10'd48;
  localparam logic [9:0] DEF_V_ACTIVE = 10'd480;
  localparam logic [9:0] DEF_V_FP = 10'd10;
  localparam logic [9:0] DEF_V_SYNC = 10'd2;
  localparam logic [9:0] DEF_V_BP = 10'd33;
  localparam logic [9:0] DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam logic [9:0] DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam logic [9:0] DEF_X0 = 10'd256;
  localparam logic [9:0] DEF_Y0 = 10'd176;
  localparam int DEF_SCALE_LOG2 = 3;
  localparam rgb565_t DEF_FG_COLOR = 16'hFFFF;
  localparam rgb565_t DEF_BG_COLOR = 16'h001F;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v counters with registered sync and display-enable decode
module vga_timing
  import vga_pkg::*;
#(
  parameter logic [9:0] H_ACTIVE = DEF_H_ACTIVE,
  parameter logic [9:0] H_FP = DEF_H_FP,
  parameter logic [9:0] H_SYNC = DEF_H_SYNC,
  parameter logic [9:0] H_BP = DEF_H_BP,
  parameter logic [9:0] V_ACTIVE = DEF_V_ACTIVE,
  parameter logic [9:0] V_FP = DEF_V_FP,
  parameter logic [9:0] V_SYNC = DEF_V_SYNC,
  parameter logic [9:0] V_BP = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       de
);
  localparam logic [9:0] HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  always_comb active = h < H_ACTIVE && v < V_ACTIVE;
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= 10'd0;
      v <= 10'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de <= 1'b0;
    end else begin
      h <= (h == HT - 10'd1) ? 10'd0 : h + 10'd1;
      if (h == HT - 10'd1) v <= (v == VT - 10'd1) ? 10'd0 : v + 10'd1;
      hsync <= !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
      vsync <= !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      de <= active;
    end
  end
endmodule

// File: rtl/vga_ram_display.sv
// vga_ram_display: renders a 16x16 RAM bitmap on VGA, fetching rows in hblank
module vga_ram_display
  import vga_pkg::*;
#(
  parameter logic [9:0] H_ACTIVE = DEF_H_ACTIVE,
  parameter logic [9:0] H_FP = DEF_H_FP,
  parameter logic [9:0] H_SYNC = DEF_H_SYNC,
  parameter logic [9:0] H_BP = DEF_H_BP,
  parameter logic [9:0] V_ACTIVE = DEF_V_ACTIVE,
  parameter logic [9:0] V_FP = DEF_V_FP,
  parameter logic [9:0] V_SYNC = DEF_V_SYNC,
  parameter logic [9:0] V_BP = DEF_V_BP,
  parameter logic [9:0] X0 = DEF_X0,
  parameter logic [9:0] Y0 = DEF_Y0,
  parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
  parameter rgb565_t FG_COLOR = DEF_FG_COLOR,
  parameter rgb565_t BG_COLOR = DEF_BG_COLOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_busy,
  output logic [3:0]  read_addr,
  input  logic [15:0] read_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] rgb,
  output logic        frame_start,
  output logic        underrun
);
  localparam logic [9:0] HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] BOX = 10'(16 << SCALE_LOG2);
  logic [9:0] h, v, dx, dy, ny;
  logic [3:0] col, row;
  logic active, in_box, trigger, abort;
  logic [15:0] line_buf;
  rgb565_t pix;
  fetch_t state, next;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .h(h), .v(v), .active(active),
    .hsync(hsync), .vsync(vsync), .de(de)
  );
  always_comb begin
    dx = h - X0;
    ny = (v == VT - 10'd1) ? 10'd0 : v + 10'd1;
    dy = ny - Y0;
    col = 4'(dx >> SCALE_LOG2);
    row = 4'(dy >> SCALE_LOG2);
    in_box = h >= X0 && h < X0 + BOX && v >= Y0 && v < Y0 + BOX;
    pix = !active ? 16'h0000 : (in_box && line_buf[~col]) ? FG_COLOR : BG_COLOR;
    trigger = h == H_ACTIVE && ny >= Y0 && ny < Y0 + BOX;
    abort = state == REQ && h == HT - 10'd1;
    next = state;
    next = state == IDLE ? (trigger ? REQ : IDLE) :
           state == REQ  ? (abort ? IDLE : ram_busy ? REQ : CAPT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      line_buf <= 16'h0000;
      read_addr <= 4'd0;
      rgb <= 16'h0000;
      frame_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rgb <= pix;
      frame_start <= h == 10'd0 && v == 10'd0;
      underrun <= abort;
      if (state == IDLE && trigger) read_addr <= row;
      if (state == CAPT) line_buf <= read_data;
    end
  end
endmodule
